// File: rtl/video_layer_mixer.sv
// Video layer mixer: sums per-layer palette colours of up to 8 one-bit video
// layers through a 3-stage ce_pix-gated pipeline, saturates each channel and
// optionally inverts the whole frame. Inversion requests seen during one frame
// take effect from the next vsync rising edge.
module video_layer_mixer #(
  parameter int LAYERS    = 3,
  parameter int CW        = 4,
  parameter int INV_LAYER = LAYERS
) (
  input  logic                clk_vid,
  input  logic                reset_n,
  input  logic                ce_pix,
  input  logic [LAYERS-1:0]   layer_in,
  input  logic                inv_req,
  input  logic [LAYERS-1:0]   layer_en,
  input  logic                color_en,
  input  logic                inv_en,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblank_in,
  input  logic                vblank_in,
  input  logic                cfg_we,
  input  logic                cfg_bank,
  input  logic [2:0]          cfg_layer,
  input  logic [3*CW-1:0]     cfg_rgb,
  output logic [CW-1:0]       r_out,
  output logic [CW-1:0]       g_out,
  output logic [CW-1:0]       b_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblank_out,
  output logic                vblank_out,
  output logic                inv_active
);

  // Sum width: up to 8 layers of (2^CW-1) never overflows CW+3 bits.
  localparam int SW = CW + 3;

  // Mid-scale palette reset value, replicated over {r,g,b}.
  localparam logic [CW-1:0]   PAL_RST     = {1'b0, {(CW-1){1'b1}}};
  localparam logic [3*CW-1:0] PAL_RST_RGB = {3{PAL_RST}};

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } timing_t;

  // Palette: [bank][layer] of {r,g,b}.
  logic [3*CW-1:0] pal_q [2][LAYERS];

  // Pipeline state.
  logic [LAYERS-1:0] s1_lay_q;
  logic              s1_inv_q;
  timing_t           s1_tim_q, s2_tim_q, s3_tim_q;
  logic [SW-1:0]     s2_r_q, s2_g_q, s2_b_q;
  logic [SW-1:0]     sum_r_d, sum_g_d, sum_b_d;
  logic [CW-1:0]     r_q, g_q, b_q;

  // Frame-inversion state.
  logic cur_inv_q;
  logic inv_active_q;
  logic vs_prev_q;
  logic vs_rise;
  logic inv_bit;
  logic [CW-1:0] inv_mask;

  // The inversion request is either a dedicated pin or one of the layer bits.
  generate
    if (INV_LAYER == LAYERS) begin : g_inv_pin
      assign inv_bit = inv_req;
    end else begin : g_inv_layer
      assign inv_bit = layer_in[INV_LAYER];
    end
  endgenerate

  assign vs_rise  = s1_tim_q.vs & ~vs_prev_q;
  assign inv_mask = {CW{inv_active_q & inv_en}};

  function automatic logic [CW-1:0] saturate(input logic [SW-1:0] s);
    return (s[SW-1:CW] != '0) ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  // Palette register file; writes are independent of ce_pix, and an index
  // beyond the last layer matches no entry so it is dropped.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the palette is a small register array, not RAM, so it can and
      // must take a defined reset value in every entry.
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < LAYERS; l++)
          pal_q[b][l] <= PAL_RST_RGB;
    end else if (cfg_we) begin
      for (int l = 0; l < LAYERS; l++)
        if (cfg_layer == 3'(l))
          pal_q[cfg_bank][l] <= cfg_rgb;
    end
  end

  // Stage-2 adder tree over the live palette bank for every active layer.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update, otherwise a path without assignment would infer a latch.
    sum_r_d = '0;
    sum_g_d = '0;
    sum_b_d = '0;
    for (int l = 0; l < LAYERS; l++) begin
      if (s1_lay_q[l]) begin
        sum_r_d = sum_r_d + {3'b000, pal_q[color_en][l][3*CW-1 -: CW]};
        sum_g_d = sum_g_d + {3'b000, pal_q[color_en][l][2*CW-1 -: CW]};
        sum_b_d = sum_b_d + {3'b000, pal_q[color_en][l][CW-1 -: CW]};
      end
    end
  end

  // Three pixel stages: capture, sum, saturate/invert; all hold when ce_pix=0.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and stage order in the block is irrelevant.
      s1_lay_q <= '0;
      s1_inv_q <= 1'b0;
      s1_tim_q <= '0;
      s2_r_q   <= '0;
      s2_g_q   <= '0;
      s2_b_q   <= '0;
      s2_tim_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      s3_tim_q <= '0;
    end else if (ce_pix) begin
      s1_lay_q <= layer_in & layer_en;
      s1_inv_q <= inv_bit;
      s1_tim_q <= {hsync_in, vsync_in, hblank_in, vblank_in};
      s2_r_q   <= sum_r_d;
      s2_g_q   <= sum_g_d;
      s2_b_q   <= sum_b_d;
      s2_tim_q <= s1_tim_q;
      r_q      <= saturate(s2_r_q) ^ inv_mask;
      g_q      <= saturate(s2_g_q) ^ inv_mask;
      b_q      <= saturate(s2_b_q) ^ inv_mask;
      s3_tim_q <= s2_tim_q;
    end
  end

  // Accumulate requests over a frame and latch them at the vsync rising edge;
  // the edge pixel's own request starts the new frame's accumulation.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      cur_inv_q    <= 1'b0;
      inv_active_q <= 1'b0;
      vs_prev_q    <= 1'b0;
    end else if (ce_pix) begin
      vs_prev_q <= s1_tim_q.vs;
      if (vs_rise) begin
        inv_active_q <= cur_inv_q;
        cur_inv_q    <= s1_inv_q;
      end else begin
        cur_inv_q    <= cur_inv_q | s1_inv_q;
      end
    end
  end

  assign r_out      = r_q;
  assign g_out      = g_q;
  assign b_out      = b_q;
  assign hsync_out  = s3_tim_q.hs;
  assign vsync_out  = s3_tim_q.vs;
  assign hblank_out = s3_tim_q.hb;
  assign vblank_out = s3_tim_q.vb;
  assign inv_active = inv_active_q;

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed-vector bench for video_layer_mixer (default parameters). The driver
// pushes each pixel's hand-computed colour and timing into a scoreboard; a
// monitor pops one entry per ce_pix pulse once the pipeline is full.
module tb_video_layer_mixer;

  logic        clk_vid;
  logic        reset_n;
  logic        ce_pix;
  logic [2:0]  layer_in;
  logic        inv_req;
  logic [2:0]  layer_en;
  logic        color_en;
  logic        inv_en;
  logic        hsync_in, vsync_in, hblank_in, vblank_in;
  logic        cfg_we;
  logic        cfg_bank;
  logic [2:0]  cfg_layer;
  logic [11:0] cfg_rgb;
  logic [3:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out, hblank_out, vblank_out;
  logic        inv_active;

  video_layer_mixer dut (
    .clk_vid    (clk_vid),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .layer_in   (layer_in),
    .inv_req    (inv_req),
    .layer_en   (layer_en),
    .color_en   (color_en),
    .inv_en     (inv_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .cfg_we     (cfg_we),
    .cfg_bank   (cfg_bank),
    .cfg_layer  (cfg_layer),
    .cfg_rgb    (cfg_rgb),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblank_out (hblank_out),
    .vblank_out (vblank_out),
    .inv_active (inv_active)
  );

  initial clk_vid = 1'b0;
  always #5 clk_vid = ~clk_vid;

  typedef struct {
    int         idx;
    logic       chk;
    logic [11:0] rgb;
    logic [3:0]  tim;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   pulses  = 0;
  int   cnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: output after pulse n belongs to the pixel captured at pulse n-2.
  always @(posedge clk_vid) begin
    if (reset_n && ce_pix) begin
      pulses++;
      if (pulses >= 3) begin
        #1;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_empty: output at pulse %0d with no expected pixel", pulses);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk) begin
            check($sformatf("pix%0d_rgb", e.idx), 32'({r_out, g_out, b_out}), 32'(e.rgb));
            check($sformatf("pix%0d_timing", e.idx),
                  32'({hsync_out, vsync_out, hblank_out, vblank_out}), 32'(e.tim));
          end
        end
      end
    end
  end

  // One pixel with ce_pix high for one clock; timing bits vary with cnt.
  task automatic pix(input logic [2:0] lay, input logic [2:0] en, input logic vs,
                     input logic inv, input logic [11:0] rgb, input logic chk);
    logic hs, hb, vb;
    @(negedge clk_vid);
    hs = cnt[0];
    hb = cnt[1];
    vb = cnt[2] ^ cnt[0];
    layer_in  = lay;
    layer_en  = en;
    vsync_in  = vs;
    inv_req   = inv;
    hsync_in  = hs;
    hblank_in = hb;
    vblank_in = vb;
    ce_pix    = 1'b1;
    sb.push_back('{cnt, chk, rgb, {hs, vs, hb, vb}});
    cnt++;
  endtask

  task automatic px(input logic [2:0] lay, input logic vs, input logic inv, input logic [11:0] rgb);
    pix(lay, 3'b111, vs, inv, rgb, 1'b1);
  endtask

  task automatic idle(input int n, input logic scramble);
    repeat (n) begin
      @(negedge clk_vid);
      ce_pix = 1'b0;
      if (scramble) begin
        layer_in  = 3'($urandom);
        inv_req   = 1'($urandom);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblank_in = 1'($urandom);
        vblank_in = 1'($urandom);
      end
    end
  endtask

  task automatic cfg(input logic bank, input logic [2:0] lay, input logic [11:0] rgb);
    @(negedge clk_vid);
    ce_pix    = 1'b0;
    cfg_we    = 1'b1;
    cfg_bank  = bank;
    cfg_layer = lay;
    cfg_rgb   = rgb;
    @(negedge clk_vid);
    cfg_we    = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    ce_pix   = 1'b0;
    layer_in = '0;
    inv_req  = 1'b0;
    layer_en = 3'b111;
    color_en = 1'b0;
    inv_en   = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
    cfg_we = 1'b0; cfg_bank = 1'b0; cfg_layer = '0; cfg_rgb = '0;

    #23;
    check("reset_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    check("reset_timing", 32'({hsync_out, vsync_out, hblank_out, vblank_out}), 32'h0);
    check("reset_inv_active", 32'(inv_active), 32'h0);
    @(negedge clk_vid);
    reset_n = 1'b1;

    // Bank 0 reset palette (0x777 per layer).
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b111, 1'b0, 1'b0, 12'hFFF);
    px(3'b001, 1'b0, 1'b0, 12'h777);
    px(3'b000, 1'b0, 1'b0, 12'h000);

    // Bank 1 programming, plus an out-of-range write that must be dropped.
    cfg(1'b1, 3'd2, 12'hFF0);
    cfg(1'b1, 3'd1, 12'h0FF);
    cfg(1'b0, 3'd5, 12'h000);
    color_en = 1'b1;
    px(3'b110, 1'b0, 1'b0, 12'hFFF);
    px(3'b010, 1'b0, 1'b0, 12'h0FF);
    px(3'b001, 1'b0, 1'b0, 12'h777);
    pix(3'b110, 3'b100, 1'b0, 1'b0, 12'hFF0, 1'b1);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    idle(1, 1'b0);
    color_en = 1'b0;
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'h000);

    // ce_pix hold with changing inputs.
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b111, 1'b0, 1'b0, 12'hFFF);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    idle(10, 1'b1);
    check("hold_rgb", 32'({r_out, g_out, b_out}), 32'hEEE);
    check("hold_inv_active", 32'(inv_active), 32'h0);
    px(3'b001, 1'b0, 1'b0, 12'h777);

    // Frame 1: request mid-frame, no inversion yet.
    px(3'b011, 1'b1, 1'b0, 12'hEEE);
    px(3'b011, 1'b1, 1'b0, 12'hEEE);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b011, 1'b0, 1'b1, 12'hEEE);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    idle(1, 1'b0);
    check("f1_inv_active", 32'(inv_active), 32'h0);

    // Frame 2: inverted from its vsync rise; inv_en masks without side effects.
    px(3'b000, 1'b1, 1'b0, 12'hFFF);
    px(3'b000, 1'b1, 1'b0, 12'hFFF);
    px(3'b011, 1'b0, 1'b0, 12'h111);
    px(3'b011, 1'b0, 1'b0, 12'h111);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    idle(1, 1'b0);
    inv_en = 1'b0;
    check("f2_inv_active", 32'(inv_active), 32'h1);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);
    idle(1, 1'b0);
    inv_en = 1'b1;
    check("f2_inv_active_kept", 32'(inv_active), 32'h1);
    px(3'b011, 1'b0, 1'b0, 12'h111);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);

    // Frame 3: no requests in frame 2 -> normal; edge-pixel request counts here.
    px(3'b011, 1'b1, 1'b1, 12'hEEE);
    px(3'b011, 1'b1, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    idle(1, 1'b0);
    check("f3_inv_active", 32'(inv_active), 32'h0);

    // Frame 4: inverted by the edge-pixel request of frame 3.
    px(3'b011, 1'b1, 1'b0, 12'h111);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);
    idle(1, 1'b0);
    check("f4_inv_active", 32'(inv_active), 32'h1);

    // Mid-frame reset after a request.
    px(3'b000, 1'b0, 1'b1, 12'hFFF);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);
    px(3'b000, 1'b0, 1'b0, 12'hFFF);
    @(negedge clk_vid);
    ce_pix  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    check("midrst_inv_active", 32'(inv_active), 32'h0);
    sb.delete();
    pulses = 0;
    @(negedge clk_vid);
    reset_n = 1'b1;

    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b011, 1'b1, 1'b0, 12'hEEE);
    px(3'b000, 1'b1, 1'b0, 12'h000);
    idle(1, 1'b0);
    check("postrst_inv_active", 32'(inv_active), 32'h0);
    px(3'b011, 1'b0, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'h000);

    // Bank 1 restored to reset value.
    idle(1, 1'b0);
    color_en = 1'b1;
    px(3'b110, 1'b0, 1'b0, 12'hEEE);
    px(3'b000, 1'b0, 1'b0, 12'h000);
    pix(3'b000, 3'b111, 1'b0, 1'b0, 12'h000, 1'b0);
    pix(3'b000, 3'b111, 1'b0, 1'b0, 12'h000, 1'b0);
    idle(3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_layer_mixer.md
VIDEO_LAYER_MIXER -- requirements
Module: video_layer_mixer

Interface
REQ-001 SHALL have parameter LAYERS, default 3, number of 1-bit video layers mixed (1..8).
REQ-002 SHALL have parameter CW, default 4, bits per colour channel (2..8).
REQ-003 SHALL have parameter INV_LAYER, default LAYERS, index of the inversion-request input bit; INV_LAYER=LAYERS selects a dedicated inv_req input.
REQ-004 SHALL have ports:
  clk_vid  in  1  video clock, all logic on its rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  ce_pix  in  1  pixel enable; pipeline advances only when high.
  layer_in  in  LAYERS  per-layer pixel-on bits.
  inv_req  in  1  per-pixel inversion request.
  layer_en  in  LAYERS  per-layer mask; 0 forces that layer off.
  color_en  in  1  0 selects palette bank 0 (mono), 1 selects bank 1 (colour).
  inv_en  in  1  1 allows frame inversion to apply.
  hsync_in, vsync_in, hblank_in, vblank_in  in  1 each  raw timing.
  cfg_we  in  1  palette write strobe.
  cfg_bank  in  1  palette bank to write.
  cfg_layer  in  3  layer index to write.
  cfg_rgb  in  3*CW  {r,g,b} palette value.
  r_out, g_out, b_out  out  CW each  mixed colour.
  hsync_out, vsync_out, hblank_out, vblank_out  out  1 each  delayed timing.
  inv_active  out  1  inversion applied to current frame.
REQ-005 Clock and reset SHALL be one clock, clk_vid, with reset_n asynchronous and active-low.

Function
REQ-006 Palette SHALL hold 2 banks x LAYERS entries of 3*CW bits in registers.
REQ-007 Palette write SHALL occur on the clock edge where cfg_we=1, independent of ce_pix; cfg_layer >= LAYERS SHALL be ignored.
REQ-008 Pipeline stage 1 (ce_pix=1) SHALL register layer_in & layer_en, inv_req (or layer_in[INV_LAYER]), and the four timing inputs.
REQ-009 Stage 2 (ce_pix=1) SHALL sum the selected-bank palette channel of every active stage-1 layer, per channel, unsigned, width CW+3, with no overflow.
REQ-010 Stage 3 (ce_pix=1) SHALL saturate each sum to 2^CW-1 when it exceeds 2^CW-1, then XOR with {CW{inv_active & inv_en}}, and register it to r/g/b_out.
REQ-011 Timing outputs SHALL be delayed exactly 3 ce_pix pulses, aligned with colour.
REQ-012 Latency SHALL be 3 ce_pix pulses from inputs to outputs; when ce_pix=0, all pipeline registers SHALL hold.
REQ-013 cur_inv SHALL OR in the stage-1 inversion bit on each ce_pix.
REQ-014 A vsync rising edge SHALL be detected on stage-1 vsync versus its previous ce_pix sample.
REQ-015 On that edge, inv_active SHALL be set to cur_inv and cur_inv set to the current stage-1 inversion bit, so a request on the edge pixel counts toward the new frame.
REQ-016 inv_active SHALL change only at a vsync rising edge; toggling inv_en SHALL mask output inversion immediately without altering inv_active or cur_inv.
REQ-017 A palette write or a color_en change SHALL affect the stage-2 result on the next ce_pix.
REQ-018 If all layers are off, the pre-invert colour SHALL be 0.

Reset
REQ-019 While reset_n=0, all outputs, pipeline registers, cur_inv, inv_active and the vsync edge register SHALL be 0.
REQ-020 Reset SHALL set every palette entry, both banks, each channel to 2^(CW-1)-1 (0x7 for CW=4).
REQ-021 Reset asserted mid-frame SHALL discard pending cur_inv; the first vsync edge after release SHALL load inv_active from requests seen since release only.

Verification
REQ-022 Defaults, CW=4: layers 0 and 1 on, bank 0 -> after 3 ce_pix, rgb=0xE,0xE,0xE; all 3 on -> 0xF,0xF,0xF (saturated).
REQ-023 Write bank1 layer2=0xFF0 and layer1=0x0FF, color_en=1, both layers on -> rgb=0xF,0xF,0xF; only layer1 on -> 0x0,0xF,0xF.
REQ-024 inv_req pulse mid-frame 1, inv_en=1 -> outputs not inverted until the frame-2 vsync rise; frame 2 all-off pixel -> 0xF,0xF,0xF; no requests in frame 2 -> frame 3 normal.
REQ-025 ce_pix held 0 for 10 clocks while inputs change -> outputs and inv_active unchanged; timing outputs stay aligned with colour at 3-pulse delay.
REQ-026 reset_n pulsed low mid-frame after inv_req -> outputs 0 immediately; next vsync edge gives inv_active=0.
REQ-027 cfg_we with cfg_layer=5, LAYERS=3 -> no palette change; layer_en=0 for a lit layer -> its colour is excluded.
